// File: rtl/rc_scheduler.sv
// Shared XY route-compute unit: round-robin grant over input-VC requesters,
// then a two-stage pipeline that returns the output direction per requester.
module rc_scheduler #(
    parameter int NUM_REQ        = 8,
    parameter int NUM_ROUTERS    = 16,
    parameter int ROUTER_PER_ROW = 4,
    parameter int DIR_BITS       = 3,
    parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
    parameter int REQ_BITS       = $clog2(NUM_REQ),
    parameter logic [DIR_BITS-1:0] DIR_EJECT = DIR_BITS'(0),
    parameter logic [DIR_BITS-1:0] DIR_EAST  = DIR_BITS'(1),
    parameter logic [DIR_BITS-1:0] DIR_WEST  = DIR_BITS'(2),
    parameter logic [DIR_BITS-1:0] DIR_NORTH = DIR_BITS'(3),
    parameter logic [DIR_BITS-1:0] DIR_SOUTH = DIR_BITS'(4)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ROUTER_ID_BITS-1:0]         current_router,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*ROUTER_ID_BITS-1:0] req_dest,
    output logic [NUM_REQ-1:0]                req_ack,
    output logic                              resp_valid,
    output logic [REQ_BITS-1:0]               resp_id,
    output logic [DIR_BITS-1:0]               resp_dir,
    output logic                              resp_err,
    output logic [NUM_REQ-1:0]                pending
);

    localparam logic [REQ_BITS:0] NREQ_W =
        (REQ_BITS+1)'(NUM_REQ);
    localparam logic [REQ_BITS-1:0] LAST_REQ =
        REQ_BITS'(NUM_REQ-1);
    localparam logic [ROUTER_ID_BITS:0] NR_W =
        (ROUTER_ID_BITS+1)'(NUM_ROUTERS);
    localparam logic [ROUTER_ID_BITS-1:0] RPR =
        ROUTER_ID_BITS'(ROUTER_PER_ROW);

    logic [REQ_BITS-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]        elig;
    logic                      grant_any;
    logic [REQ_BITS-1:0]       grant_id;
    logic [NUM_REQ-1:0]        ack_vec;
    logic [NUM_REQ-1:0]        pending_n;
    logic [ROUTER_ID_BITS-1:0] dest_arr [NUM_REQ];

    logic                      s1_valid;
    logic [REQ_BITS-1:0]       s1_id;
    logic [ROUTER_ID_BITS-1:0] s1_dest;
    logic [ROUTER_ID_BITS-1:0] s1_cur;

    logic [ROUTER_ID_BITS-1:0] ccol, crow, dcol, drow;
    logic signed [ROUTER_ID_BITS:0] dx, dy;
    logic                      s2_err;
    logic [DIR_BITS-1:0]       s2_dir;

    assign elig = req_valid & ~pending;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dest_arr[i] = req_dest[i*ROUTER_ID_BITS +: ROUTER_ID_BITS];
        end
    end

    // Rotating first-set search starting at rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin : arb
        logic [REQ_BITS:0] sum;
        logic [REQ_BITS-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (REQ_BITS+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[REQ_BITS-1:0];
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_comb begin
        ack_vec = '0;
        if (grant_any) begin
            ack_vec[grant_id] = 1'b1;
        end
    end

    assign req_ack = reset ? '0 : ack_vec;

    // A grant never targets the id being cleared: it is ineligible this cycle.
    always_comb begin
        pending_n = pending;
        if (resp_valid) begin
            pending_n[resp_id] = 1'b0;
        end
        if (grant_any) begin
            pending_n[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ccol   = s1_cur % RPR;
        crow   = s1_cur / RPR;
        dcol   = s1_dest % RPR;
        drow   = s1_dest / RPR;
        dx     = $signed({1'b0, dcol}) - $signed({1'b0, ccol});
        dy     = $signed({1'b0, drow}) - $signed({1'b0, crow});
        s2_err = ({1'b0, s1_dest} >= NR_W);
        if (s2_err || (s1_cur == s1_dest)) begin
            s2_dir = DIR_EJECT;
        end else if (dx > 0) begin
            s2_dir = DIR_EAST;
        end else if (dx < 0) begin
            s2_dir = DIR_WEST;
        end else if (dy > 0) begin
            s2_dir = DIR_NORTH;
        end else begin
            s2_dir = DIR_SOUTH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            pending    <= '0;
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_dest    <= '0;
            s1_cur     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_dir   <= DIR_EJECT;
            resp_err   <= 1'b0;
        end else begin
            pending  <= pending_n;
            s1_valid <= grant_any;
            if (grant_any) begin
                rr_ptr  <= (grant_id == LAST_REQ) ? '0 : grant_id + 1'b1;
                s1_id   <= grant_id;
                s1_dest <= dest_arr[grant_id];
                s1_cur  <= current_router;
            end
            resp_valid <= s1_valid;
            if (s1_valid) begin
                resp_id  <= s1_id;
                resp_dir <= s2_dir;
                resp_err <= s2_err;
            end else begin
                resp_dir <= DIR_EJECT;
                resp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rc_scheduler.sv
// Directed bench for rc_scheduler: reference arbiter model plus a response
// scoreboard keyed by due cycle.
module tb_rc_scheduler;

    localparam logic [2:0] EJECT = 3'd0;
    localparam logic [2:0] EAST  = 3'd1;
    localparam logic [2:0] WEST  = 3'd2;
    localparam logic [2:0] NORTH = 3'd3;
    localparam logic [2:0] SOUTH = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cur;
    logic [7:0]  req_valid;
    logic [31:0] req_dest;
    logic [7:0]  req_ack;
    logic        resp_valid;
    logic [2:0]  resp_id;
    logic [2:0]  resp_dir;
    logic        resp_err;
    logic [7:0]  pending;

    logic [3:0]  cur_b;
    logic [7:0]  req_valid_b;
    logic [31:0] req_dest_b;
    logic [7:0]  req_ack_b;
    logic        resp_valid_b;
    logic [2:0]  resp_id_b;
    logic [2:0]  resp_dir_b;
    logic        resp_err_b;
    logic [7:0]  pending_b;

    rc_scheduler #(
        .NUM_REQ(8), .NUM_ROUTERS(16),
        .ROUTER_PER_ROW(4), .DIR_BITS(3)
    ) dut (
        .clk(clk), .reset(reset), .current_router(cur),
        .req_valid(req_valid), .req_dest(req_dest),
        .req_ack(req_ack), .resp_valid(resp_valid),
        .resp_id(resp_id), .resp_dir(resp_dir),
        .resp_err(resp_err), .pending(pending)
    );

    rc_scheduler #(
        .NUM_REQ(8), .NUM_ROUTERS(12),
        .ROUTER_PER_ROW(4), .DIR_BITS(3)
    ) dut12 (
        .clk(clk), .reset(reset), .current_router(cur_b),
        .req_valid(req_valid_b), .req_dest(req_dest_b),
        .req_ack(req_ack_b), .resp_valid(resp_valid_b),
        .resp_id(resp_id_b), .resp_dir(resp_dir_b),
        .resp_err(resp_err_b), .pending(pending_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] id;
        logic [2:0] dir;
        logic       err;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] pend_m;
    int         rr_m;
    logic       clr_v;
    logic [2:0] clr_id;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] xy(logic [3:0] c, logic [3:0] d);
        int cc, cr, dc, dr;
        cc = int'(c) % 4; cr = int'(c) / 4;
        dc = int'(d) % 4; dr = int'(d) / 4;
        if (c == d) return EJECT;
        if (dc > cc) return EAST;
        if (dc < cc) return WEST;
        if (dr > cr) return NORTH;
        return SOUTH;
    endfunction

    task automatic set_dest(int i, logic [3:0] d);
        req_dest[i*4 +: 4] = d;
    endtask

    task automatic tick();
        logic [7:0] exp_ack;
        int g, idx;
        exp_t e;
        #1;
        exp_ack = '0;
        g = -1;
        if (!reset) begin
            for (int k = 0; k < 8; k++) begin
                idx = (rr_m + k) % 8;
                if (g < 0 && req_valid[idx] && !pend_m[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ack[g] = 1'b1;
        chk("req_ack", {24'd0, req_ack}, {24'd0, exp_ack});
        if (clr_v) pend_m[clr_id] = 1'b0;
        clr_v = 1'b0;
        if (g >= 0) begin
            pend_m[g] = 1'b1;
            rr_m = (g + 1) % 8;
            e.id  = 3'(g);
            e.dir = xy(cur, req_dest[g*4 +: 4]);
            e.err = 1'b0;
            e.due = cyc + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc++;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_id", {29'd0, resp_id}, {29'd0, e.id});
                chk("resp_dir", {29'd0, resp_dir}, {29'd0, e.dir});
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_latency", cyc, e.due);
                clr_v  = 1'b1;
                clr_id = e.id;
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("resp_missing", {31'd0, resp_valid}, 32'd1);
            void'(sb.pop_front());
        end
        chk("pending", {24'd0, pending}, {24'd0, pend_m});
    endtask

    task automatic model_clear();
        pend_m = '0;
        rr_m   = 0;
        clr_v  = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        model_clear();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() > 0 && b < 10) begin
            tick();
            b++;
        end
        if (sb.size() > 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL drain_timeout: observed %0d queued expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin : main
        logic [3:0] dl [5];
        int first_rv, last_rv, n_rv, cnt;
        reset = 1'b1;
        cur = '0;
        req_valid = '0;
        req_dest = '0;
        cur_b = '0;
        req_valid_b = '0;
        req_dest_b = '0;
        model_clear();
        @(negedge clk);

        // Reset values, with requests raised to show req_ack is held low.
        req_valid = 8'hFF;
        #1;
        chk("rst_ack", {24'd0, req_ack}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {29'd0, resp_id}, 32'd0);
        chk("rst_resp_dir", {29'd0, resp_dir}, {29'd0, EJECT});
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_pending", {24'd0, pending}, 32'd0);
        req_valid = '0;
        do_reset(2);

        // Single requester, each direction in turn from router 5.
        cur = 4'd5;
        dl = '{4'd7, 4'd4, 4'd13, 4'd1, 4'd5};
        for (int i = 0; i < 5; i++) begin
            set_dest(0, dl[i]);
            req_valid = 8'h01;
            tick();
            req_valid = '0;
            drain();
        end

        // All requesters at once from reset, each dropping on its response.
        do_reset(2);
        for (int i = 0; i < 8; i++) set_dest(i, 4'((i * 5 + 3) % 16));
        req_valid = 8'hFF;
        first_rv = -1;
        last_rv = -1;
        n_rv = 0;
        for (int t = 0; t < 14; t++) begin
            tick();
            if (resp_valid) begin
                req_valid[resp_id] = 1'b0;
                if (first_rv < 0) first_rv = cyc;
                last_rv = cyc;
                n_rv++;
            end
        end
        chk("burst_count", n_rv, 32'd8);
        chk("burst_span", last_rv - first_rv + 1, 32'd8);
        req_valid = '0;
        drain();

        // Grant 2 to move the pointer to 3, then {1,6} must wrap.
        set_dest(2, 4'd2);
        req_valid = 8'h04;
        tick();
        req_valid = '0;
        drain();
        set_dest(1, 4'd9);
        set_dest(6, 4'd6);
        req_valid = 8'h42;
        #1;
        chk("wrap_first", {24'd0, req_ack}, 32'h40);
        tick();
        req_valid[6] = 1'b0;
        #1;
        chk("wrap_second", {24'd0, req_ack}, 32'h02);
        tick();
        req_valid = '0;
        drain();

        // Held request: one grant while pending, the next after the response.
        set_dest(2, 4'd15);
        req_valid = 8'h04;
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (req_ack[2]) cnt++;
            tick();
        end
        chk("hold_grants", cnt, 32'd2);
        req_valid = '0;
        drain();

        // Out-of-range destination on a 12-router mesh, then an in-range one.
        cur_b = 4'd5;
        req_dest_b[3:0] = 4'd14;
        req_valid_b = 8'h01;
        #1;
        chk("b_ack", {24'd0, req_ack_b}, 32'h01);
        tick();
        req_valid_b = '0;
        tick();
        chk("b_err_valid", {31'd0, resp_valid_b}, 32'd1);
        chk("b_err_id", {29'd0, resp_id_b}, 32'd0);
        chk("b_err", {31'd0, resp_err_b}, 32'd1);
        chk("b_err_dir", {29'd0, resp_dir_b}, {29'd0, EJECT});
        tick();
        chk("b_pulse", {31'd0, resp_valid_b}, 32'd0);
        req_dest_b[3:0] = 4'd11;
        req_valid_b = 8'h01;
        tick();
        req_valid_b = '0;
        tick();
        chk("b_ok_valid", {31'd0, resp_valid_b}, 32'd1);
        chk("b_ok_err", {31'd0, resp_err_b}, 32'd0);
        chk("b_ok_dir", {29'd0, resp_dir_b}, {29'd0, EAST});
        tick();

        // Reset one cycle after a grant discards it and rewinds the pointer.
        set_dest(5, 4'd0);
        req_valid = 8'h20;
        tick();
        req_valid = '0;
        do_reset(3);
        chk("mid_rst_pending", {24'd0, pending}, 32'd0);
        chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
        set_dest(7, 4'd12);
        req_valid = 8'hA0;
        #1;
        chk("post_rst_first", {24'd0, req_ack}, 32'h20);
        tick();
        req_valid = 8'h80;
        tick();
        req_valid = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
